buzzer_sequencer: RTL
=====================

Name: buzzer_sequencer

Overview:
- Shares one tone generator, a clockDivider instance, among NUM_REQ requesters.
- Each requester supplies a beep-pattern descriptor: divider speed, on-time, off-time and repeat count.
- The block arbitrates, latches the winning descriptor and sequences on/off phases in millisecond ticks.
- It drives the divider's speed and reset, plus a buzz_en gate that the top level ANDs with the divider's outClk.

Parameters:
- NUM_REQ, 4, number of requesters.
- SPEED_W, 20, width of the divider speed value.
- DUR_W, 12, width of on/off durations in ms ticks.
- REP_W, 4, width of the repeat count.
- TICK_DIV, 50000, clk cycles per ms tick (50 MHz clock).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until granted.
- req_speed  in  NUM_REQ*SPEED_W  packed speed values; requester i occupies slice i.
- req_on  in  NUM_REQ*DUR_W  packed on-durations in ticks.
- req_off  in  NUM_REQ*DUR_W  packed off-durations in ticks.
- req_reps  in  NUM_REQ*REP_W  packed repeat counts.
- abort  in  1  cancels the pattern in progress.
- grant  out  NUM_REQ  one-hot, one-cycle accept pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- speed  out  SPEED_W  speed value to clockDivider.
- div_reset  out  1  reset to clockDivider.
- buzz_en  out  1  tone gate.

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-high.
- All outputs are registered.
- Reset values: grant=0, busy=0, done=0, speed=0, div_reset=1, buzz_en=0, state=IDLE.
- FSM states: IDLE, LOAD, ON, OFF.
- IDLE:
  - If any req bit is high, select the winner by fixed priority (lowest index wins).
  - Next cycle: grant[winner]=1 for exactly one cycle; winner's descriptor latched; state goes to LOAD.
  - Requests arriving while busy are ignored until IDLE. No queueing.
- LOAD (1 cycle):
  - speed=latched speed, div_reset=1, rep counter = reps.
  - If reps==0: done pulses, state returns to IDLE, no sound.
  - Otherwise go to ON; if on==0, go straight to OFF.
- ON:
  - buzz_en=1, div_reset=0.
  - Lasts exactly on*TICK_DIV cycles.
  - The tick prescaler and duration counter clear on every phase entry, so no partial first tick.
  - At expiry, decrement the rep counter. If it reaches 0: done, IDLE. Else go to OFF (or straight to ON if off==0).
- OFF:
  - buzz_en=0, div_reset=1.
  - Lasts exactly off*TICK_DIV cycles, then goes to ON.
  - No OFF phase follows the final repetition.
- Latency: buzz_en rises 3 cycles after req is first sampled high in IDLE (grant cycle, LOAD cycle, then ON).
- done: asserted the cycle the FSM enters IDLE after the last phase. busy drops in the same cycle.
- abort:
  - Sampled in any non-IDLE state.
  - Next cycle: IDLE, buzz_en=0, div_reset=1, no done pulse.
  - abort in IDLE is ignored. abort and req in the same IDLE cycle: the req is granted.
- speed holds its last value in IDLE. div_reset=1 in IDLE.
- Counter widths: duration counter DUR_W bits, prescaler width $clog2(TICK_DIV). Terminal-count compare, no wrap.
- Reset mid-pattern: immediate return to reset values, with no done pulse.

Optional Feature:
- Macro: BUZZ_RR_ARB_EN.
- Defined: round-robin arbitration. A pointer holds the index after the last granted requester; the search starts there and wraps. Pointer resets to 0.
- Undefined: fixed priority, lowest index wins.
- FSM timing is identical in both builds.

Decomposition:
- Package buzzer_pkg: state enum (IDLE, LOAD, ON, OFF) and a descriptor struct {speed, on, off, reps} sized by the default widths.
- Sub-module buzzer_arbiter: combinational winner selection from req, plus the round-robin pointer register when BUZZ_RR_ARB_EN is defined.
- The FSM and counters stay in buzzer_sequencer.

Test Plan:
(All scenarios use TICK_DIV=10.)
1. Single pattern: req[2]=1 with speed=500, on=3, off=2, reps=2 -> grant=0100 for one cycle; buzz_en high 30 cycles, low 20, high 30; done pulse; speed=500 throughout; div_reset low only while buzz_en is high.
2. Contention: req=1010 in the same cycle -> grant=0010. Fixed build: requester 3 is granted after done. RR build: a repeat of req=1010 then grants 1000.
3. Edge counts:
   - reps=0 -> grant, then done 2 cycles later, buzz_en never rises.
   - on=0, reps=3 -> buzz_en stays 0, OFF timing only (two OFF phases, 20 cycles each).
4. abort during the second ON phase -> buzz_en=0 and div_reset=1 next cycle; busy drops; no done; a new req is accepted the following cycle.
5. reset asserted asynchronously mid-OFF -> all outputs take reset values without waiting for a clk edge; a req after reset release is granted normally.
6. Busy rejection: req[0] asserted while a pattern plays -> no grant until done; grant=0001 one cycle after IDLE is entered.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared types for the buzzer sequencer: FSM state encoding and the latched
// beep-pattern descriptor (sized by the default field widths).
package buzzer_pkg;

    localparam int unsigned SPEED_W_DEF = 20;
    localparam int unsigned DUR_W_DEF   = 12;
    localparam int unsigned REP_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ON,
        OFF
    } state_t;

    typedef struct packed {
        logic [SPEED_W_DEF-1:0] speed;
        logic [DUR_W_DEF-1:0]   on;
        logic [DUR_W_DEF-1:0]   off;
        logic [REP_W_DEF-1:0]   reps;
    } desc_t;

endpackage

// File: rtl/buzzer_arbiter.sv
// Winner selection among requesters. Fixed priority (lowest index) by default;
// round-robin with a wrap-around pointer when BUZZ_RR_ARB_EN is defined.
module buzzer_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = 2
) (
`ifdef BUZZ_RR_ARB_EN
    input  logic               clk,
    input  logic               reset,
    input  logic               accept,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic               any,
    output logic [IW-1:0]      win
);

`ifdef BUZZ_RR_ARB_EN
    logic [IW-1:0] ptr;
    int unsigned   idx;

    // Search starts at the slot after the last grant and wraps.
    always_comb begin
        any = 1'b0;
        win = '0;
        idx = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!any && req[IW'(idx)]) begin
                any = 1'b1;
                win = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
        end
    end
`else
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any && req[IW'(i)]) begin
                any = 1'b1;
                win = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/buzzer_sequencer.sv
// Arbitrates beep-pattern requests and sequences ON/OFF phases in ms ticks for a
// shared clockDivider. Build option: BUZZ_RR_ARB_EN selects round-robin arbitration.
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned SPEED_W  = 20,
    parameter int unsigned DUR_W    = 12,
    parameter int unsigned REP_W    = 4,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*SPEED_W-1:0] req_speed,
    input  logic [NUM_REQ*DUR_W-1:0]   req_on,
    input  logic [NUM_REQ*DUR_W-1:0]   req_off,
    input  logic [NUM_REQ*REP_W-1:0]   req_reps,
    input  logic                       abort,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic                       done,
    output logic [SPEED_W-1:0]         speed,
    output logic                       div_reset,
    output logic                       buzz_en
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t            state;
    desc_t             desc;
    logic [REP_W-1:0]  rep;
    logic [DUR_W-1:0]  dur;
    logic [PW-1:0]     presc;

    logic              any;
    logic [IW-1:0]     win;
    logic [SPEED_W-1:0] d_speed;
    logic [DUR_W-1:0]  d_on, d_off, phase_len;
    logic [REP_W-1:0]  d_reps;
    logic              tick_end, phase_end, rep_last;

    buzzer_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
`ifdef BUZZ_RR_ARB_EN
        .clk    (clk),
        .reset  (reset),
        .accept (state == IDLE && any),
`endif
        .req    (req),
        .any    (any),
        .win    (win)
    );

    assign d_speed   = SPEED_W'(desc.speed);
    assign d_on      = DUR_W'(desc.on);
    assign d_off     = DUR_W'(desc.off);
    assign d_reps    = REP_W'(desc.reps);
    assign phase_len = (state == ON) ? d_on : d_off;
    assign tick_end  = (presc == PW'(TICK_DIV - 1));
    assign phase_end = tick_end && (dur == phase_len - DUR_W'(1));
    assign rep_last  = (rep == REP_W'(1));

    // LOAD spans two cycles: the grant cycle (grant != 0) and the load cycle,
    // which keeps buzz_en three cycles behind the first sampled request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            speed     <= '0;
            div_reset <= 1'b1;
            buzz_en   <= 1'b0;
            desc      <= '0;
            rep       <= '0;
            dur       <= '0;
            presc     <= '0;
        end else begin
            grant <= '0;
            done  <= 1'b0;
            if (state != IDLE && abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                buzz_en   <= 1'b0;
                div_reset <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (any) begin
                            grant      <= NUM_REQ'(1) << win;
                            desc.speed <= SPEED_W_DEF'(req_speed[win*SPEED_W +: SPEED_W]);
                            desc.on    <= DUR_W_DEF'(req_on[win*DUR_W +: DUR_W]);
                            desc.off   <= DUR_W_DEF'(req_off[win*DUR_W +: DUR_W]);
                            desc.reps  <= REP_W_DEF'(req_reps[win*REP_W +: REP_W]);
                            busy       <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (grant != '0) begin
                            speed     <= d_speed;
                            rep       <= d_reps;
                            div_reset <= 1'b1;
                        end else begin
                            presc <= '0;
                            dur   <= '0;
                            if (rep == '0 || (d_on == '0 && (rep_last || d_off == '0))) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if (d_on == '0) begin
                                // Zero-length ON completes the first repetition at once.
                                rep   <= rep - REP_W'(1);
                                state <= OFF;
                            end else begin
                                state     <= ON;
                                buzz_en   <= 1'b1;
                                div_reset <= 1'b0;
                            end
                        end
                    end
                    ON, OFF: begin
                        if (phase_end) begin
                            presc <= '0;
                            dur   <= '0;
                            if (state == OFF && d_on != '0) begin
                                state     <= ON;
                                buzz_en   <= 1'b1;
                                div_reset <= 1'b0;
                            end else if (rep_last) begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                buzz_en   <= 1'b0;
                                div_reset <= 1'b1;
                            end else begin
                                rep <= rep - REP_W'(1);
                                if (d_off != '0) begin
                                    state     <= OFF;
                                    buzz_en   <= 1'b0;
                                    div_reset <= 1'b1;
                                end
                            end
                        end else if (tick_end) begin
                            presc <= '0;
                            dur   <= dur + DUR_W'(1);
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
